// File: rtl/ram_cmd_rx.sv
// Serial command receiver: deserializes bit-clocked frames into RAM write/read strobes.
// Frame: start(1), op, addr (MSB first), data (writes only, MSB first), even parity.
module ram_cmd_rx #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              im_bite_clk,
  input  logic              im_bite_data,
  output logic              om_write_en,
  output logic              om_read_en,
  output logic [ADDR_W-1:0] om_addr,
  output logic [DATA_W-1:0] om_data,
  output logic              om_frame_err,
  output logic              om_busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StOp     = 3'd1;
  localparam logic [2:0] StAddr   = 3'd2;
  localparam logic [2:0] StData   = 3'd3;
  localparam logic [2:0] StParity = 3'd4;

  localparam int unsigned BitMax = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned BcW    = $clog2(BitMax + 1);
  localparam int unsigned TcW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BcW-1:0] AddrLast = BcW'(ADDR_W - 1);
  localparam logic [BcW-1:0] DataLast = BcW'(DATA_W - 1);
  localparam logic [TcW-1:0] ToLast   = TcW'(TIMEOUT - 1);

  logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [2:0]        state_q, state_d;
  logic              op_q, op_d;
  logic              par_q, par_d;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_W-1:0] data_sr_q, data_sr_d;
  logic [BcW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TcW-1:0]    to_cnt_q, to_cnt_d;
  logic              wr_d, rd_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              bit_edge, bit_val, timeout;

  assign bit_edge = clk_s1_q & ~clk_s2_q;
  assign bit_val  = dat_s1_q;
  assign timeout  = (state_q != StIdle) && (to_cnt_q == ToLast);
  assign om_busy  = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    par_d     = par_q;
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    bit_cnt_d = bit_cnt_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    err_d     = 1'b0;
    addr_d    = om_addr;
    data_d    = om_data;
    to_cnt_d  = (state_q == StIdle || bit_edge) ? '0 : to_cnt_q + 1'b1;
    // Timeout wins over a simultaneous edge; that edge is dropped.
    if (timeout) begin
      state_d  = StIdle;
      err_d    = 1'b1;
      to_cnt_d = '0;
    end else if (bit_edge) begin
      unique case (state_q)
        StIdle: if (bit_val) state_d = StOp;
        StOp: begin
          op_d      = bit_val;
          par_d     = bit_val;
          bit_cnt_d = '0;
          state_d   = StAddr;
        end
        StAddr: begin
          addr_sr_d = ADDR_W'({addr_sr_q, bit_val});
          par_d     = par_q ^ bit_val;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == AddrLast) begin
            bit_cnt_d = '0;
            state_d   = op_q ? StData : StParity;
          end
        end
        StData: begin
          data_sr_d = DATA_W'({data_sr_q, bit_val});
          par_d     = par_q ^ bit_val;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            state_d   = StParity;
          end
        end
        StParity: begin
          state_d = StIdle;
          if (par_q ^ bit_val) begin
            err_d = 1'b1;
          end else if (op_q) begin
            wr_d   = 1'b1;
            addr_d = addr_sr_q;
            data_d = data_sr_q;
          end else begin
            rd_d   = 1'b1;
            addr_d = addr_sr_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q     <= 1'b0;
      clk_s2_q     <= 1'b0;
      dat_s1_q     <= 1'b0;
      dat_s2_q     <= 1'b0;
      state_q      <= StIdle;
      op_q         <= 1'b0;
      par_q        <= 1'b0;
      addr_sr_q    <= '0;
      data_sr_q    <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      om_write_en  <= 1'b0;
      om_read_en   <= 1'b0;
      om_frame_err <= 1'b0;
      om_addr      <= '0;
      om_data      <= '0;
    end else begin
      clk_s1_q     <= im_bite_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= im_bite_data;
      dat_s2_q     <= dat_s1_q;
      state_q      <= state_d;
      op_q         <= op_d;
      par_q        <= par_d;
      addr_sr_q    <= addr_sr_d;
      data_sr_q    <= data_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      om_write_en  <= wr_d;
      om_read_en   <= rd_d;
      om_frame_err <= err_d;
      om_addr      <= addr_d;
      om_data      <= data_d;
    end
  end

endmodule

// File: tb/tb_ram_cmd_rx.sv
// Self-checking bench for ram_cmd_rx: table vectors, hand sequences for timeout/reset,
// and random frames checked against a frame-level reference model.
module tb_ram_cmd_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       im_bite_clk = 1'b0;
  logic       im_bite_data = 1'b0;
  logic       om_write_en, om_read_en, om_frame_err, om_busy;
  logic [2:0] om_addr;
  logic [7:0] om_data;

  ram_cmd_rx #(
    .ADDR_W (3),
    .DATA_W (8),
    .TIMEOUT(1024)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_bite_clk (im_bite_clk),
    .im_bite_data(im_bite_data),
    .om_write_en (om_write_en),
    .om_read_en  (om_read_en),
    .om_addr     (om_addr),
    .om_data     (om_data),
    .om_frame_err(om_frame_err),
    .om_busy     (om_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as extra counts.
  int wr_seen = 0, rd_seen = 0, err_seen = 0, both_seen = 0;
  always @(negedge clk) begin
    if (om_write_en) wr_seen++;
    if (om_read_en) rd_seen++;
    if (om_frame_err) err_seen++;
    if (om_write_en && om_read_en) both_seen++;
  end

  // Reference model state: last accepted address and write data.
  logic [2:0] m_addr = '0;
  logic [7:0] m_data = '0;

  typedef struct {
    logic       op;
    logic [2:0] addr;
    logic [7:0] data;
    logic       flip;
    logic       exp_wr;
    logic       exp_rd;
    logic       exp_err;
    logic [2:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic good_parity(input logic op, input logic [2:0] a,
                                       input logic [7:0] d);
    int ones;
    ones = $countones({op, a}) + (op ? $countones(d) : 0);
    return logic'(ones % 2);
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    im_bite_data = b;
    repeat (3) @(negedge clk);
    im_bite_clk = 1'b1;
    repeat (4) @(negedge clk);
    im_bite_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic op, input logic [2:0] a, input logic [7:0] d,
                            input logic par);
    send_bit(1'b1);
    send_bit(op);
    for (int i = 2; i >= 0; i--) send_bit(a[i]);
    if (op) for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(par);
  endtask

  task automatic run_frame(input string name, input logic op, input logic [2:0] a,
                           input logic [7:0] d, input logic par, input logic ewr,
                           input logic erd, input logic eerr, input logic [2:0] eaddr,
                           input logic [7:0] edata);
    int w0, r0, e0;
    w0 = wr_seen; r0 = rd_seen; e0 = err_seen;
    send_frame(op, a, d, par);
    repeat (8) @(negedge clk);
    check({name, " wr"}, wr_seen - w0, {31'd0, ewr});
    check({name, " rd"}, rd_seen - r0, {31'd0, erd});
    check({name, " err"}, err_seen - e0, {31'd0, eerr});
    check({name, " addr"}, om_addr, eaddr);
    check({name, " data"}, om_data, edata);
    check({name, " busy"}, om_busy, 1'b0);
  endtask

  // Frame-level model: accept iff the ones count over the frame body is even.
  task automatic model_frame(input logic op, input logic [2:0] a, input logic [7:0] d,
                             input logic par, output logic wr, output logic rd,
                             output logic err);
    int ones;
    ones = $countones({op, a, par}) + (op ? $countones(d) : 0);
    wr = 0; rd = 0; err = 0;
    if (ones % 2 != 0) begin
      err = 1;
    end else begin
      m_addr = a;
      if (op) begin
        m_data = d;
        wr = 1;
      end else begin
        rd = 1;
      end
    end
  endtask

  initial begin
    logic wr, rd, err, par;
    logic [2:0] a;
    logic [7:0] d;
    logic op;
    int e0, w0, waited;

    vecs[0] = '{1'b1, 3'b101, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 8'hA5};
    vecs[1] = '{1'b0, 3'b010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 8'hA5};
    vecs[2] = '{1'b1, 3'b011, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 8'hA5};
    vecs[3] = '{1'b0, 3'b111, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 8'hA5};
    vecs[4] = '{1'b1, 3'b000, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 8'hFF};
    vecs[5] = '{1'b0, 3'b110, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 8'hFF};

    repeat (3) @(negedge clk);
    check("reset wr", om_write_en, 1'b0);
    check("reset rd", om_read_en, 1'b0);
    check("reset err", om_frame_err, 1'b0);
    check("reset addr", om_addr, 3'd0);
    check("reset data", om_data, 8'd0);
    check("reset busy", om_busy, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // REQ-036 write, read, then flipped-parity frames from the table.
    for (int i = 0; i < 6; i++) begin
      par = good_parity(vecs[i].op, vecs[i].addr, vecs[i].data) ^ vecs[i].flip;
      run_frame($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, par,
                vecs[i].exp_wr, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_addr,
                vecs[i].exp_data);
    end
    m_addr = 3'b110;
    m_data = 8'hFF;

    // Timeout: start, op=1, two address bits, then silence.
    e0 = err_seen; w0 = wr_seen;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("timeout busy mid", om_busy, 1'b1);
    waited = 0;
    while (err_seen == e0 && waited < 1200) begin
      @(negedge clk);
      waited++;
    end
    check("timeout err", err_seen - e0, 1);
    check("timeout window", (waited > 1000 && waited < 1030), 1'b1);
    @(negedge clk);
    check("timeout busy", om_busy, 1'b0);
    check("timeout no wr", wr_seen - w0, 0);
    check("timeout addr", om_addr, m_addr);
    run_frame("post-timeout", 1'b1, 3'b011, 8'h5A, good_parity(1'b1, 3'b011, 8'h5A),
              1'b1, 1'b0, 1'b0, 3'b011, 8'h5A);
    m_addr = 3'b011; m_data = 8'h5A;

    // Reset in the middle of the data field.
    send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1 check("midreset busy async", om_busy, 1'b0);
    check("midreset addr async", om_addr, 3'd0);
    check("midreset data async", om_data, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_addr = '0; m_data = '0;
    e0 = err_seen; w0 = wr_seen;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b0);
      check($sformatf("zero%0d busy", i), om_busy, 1'b0);
    end
    check("midreset no err", err_seen - e0, 0);
    check("midreset no wr", wr_seen - w0, 0);
    run_frame("post-reset", 1'b1, 3'b100, 8'hC3, good_parity(1'b1, 3'b100, 8'hC3),
              1'b1, 1'b0, 1'b0, 3'b100, 8'hC3);
    m_addr = 3'b100; m_data = 8'hC3;

    // Random frames against the model.
    for (int n = 0; n < 40; n++) begin
      op  = logic'($urandom_range(0, 1));
      a   = 3'($urandom_range(0, 7));
      d   = 8'($urandom_range(0, 255));
      par = good_parity(op, a, d) ^ ($urandom_range(0, 3) == 0);
      model_frame(op, a, d, par, wr, rd, err);
      run_frame($sformatf("rand%0d", n), op, a, d, par, wr, rd, err, m_addr, m_data);
    end

    check("wr and rd never together", both_seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
